btn_event_reader: RTL

BTN_EVENT_READER -- requirements
Module: btn_event_reader

---
 rtl/btn_event_reader_if.sv | 25 ++
 rtl/btn_event_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btn_event_reader_if.sv
// Event handshake between btn_event_reader and its consumer.
//   evt_valid    : a classified event is pending (producer -> consumer)
//   evt_code     : 2'b01 short press, 2'b10 long press, 2'b00 when idle
//   evt_ack      : consumer accepts the pending event (consumer -> producer)
//   evt_overflow : sticky, an event was dropped because the slot was full
interface btn_event_reader_if;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ack;
    logic       evt_overflow;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_overflow,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_overflow,
        output evt_ack
    );
endinterface

// File: rtl/btn_event_reader.sv
// Push-button reader: synchronizes an active-low button pin, debounces press
// and release, flags long holds, counts presses and hands short/long press
// events to a consumer through a single-entry event register.
//   sys_clk       : single clock, rising edge
//   sys_rst       : synchronous active-high reset
//   user_btn_n    : raw button pin, active-low, asynchronous
//   level         : debounced pressed state
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   long_held     : current press has lasted at least LONG_CYCLES
//   press_count   : accepted presses, modulo 256
//   evt           : event handshake (master side)
module btn_event_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 15650,
    parameter int unsigned LONG_CYCLES     = 7825000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      user_btn_n,
    output logic                      level,
    output logic                      press_pulse,
    output logic                      release_pulse,
    output logic                      long_held,
    output logic [7:0]                press_count,
    btn_event_reader_if.master        evt
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

    localparam logic [1:0] EVT_NONE  = 2'b00;
    localparam logic [1:0] EVT_SHORT = 2'b01;
    localparam logic [1:0] EVT_LONG  = 2'b10;

    localparam logic [23:0] DEB_MAX  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] HOLD_MAX = 24'(LONG_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        s;
    logic [1:0]  state_q, state_d;
    logic [23:0] deb_cnt_q, deb_cnt_d;
    logic [23:0] hold_cnt_q, hold_cnt_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic [7:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic [1:0]  code_q, code_d;
    logic        ovf_q, ovf_d;
    logic        new_evt;
    logic [1:0]  new_code;

    assign s = ~sync2_q;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = long_q;
        count_d    = count_q;
        new_evt    = 1'b0;
        new_code   = EVT_NONE;

        // Hold timer runs through release bounces; long_held follows one cycle
        // after the counter reaches saturation.
        if (state_q == ST_PRESSED || state_q == ST_DEB_RELEASE) begin
            if (hold_cnt_q == HOLD_MAX) begin
                long_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 24'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d   = ST_DEB_PRESS;
                    deb_cnt_d = 24'd0;
                end
            end
            ST_DEB_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = ST_PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    count_d    = count_q + 8'd1;
                    hold_cnt_d = 24'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 24'd1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d   = ST_DEB_RELEASE;
                    deb_cnt_d = 24'd0;
                end
            end
            ST_DEB_RELEASE: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = ST_IDLE;
                    level_d    = 1'b0;
                    long_d     = 1'b0;
                    release_d  = 1'b1;
                    hold_cnt_d = 24'd0;
                    new_evt    = 1'b1;
                    new_code   = long_q ? EVT_LONG : EVT_SHORT;
                end else begin
                    deb_cnt_d = deb_cnt_q + 24'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-entry event slot; an ack in the same cycle frees it for the new event.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (new_evt) begin
            if (!valid_q || evt.evt_ack) begin
                valid_d = 1'b1;
                code_d  = new_code;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt.evt_ack) begin
            valid_d = 1'b0;
            code_d  = EVT_NONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            deb_cnt_q  <= 24'd0;
            hold_cnt_q <= 24'd0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= 8'd0;
            valid_q    <= 1'b0;
            code_q     <= EVT_NONE;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= user_btn_n;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            ovf_q      <= ovf_d;
        end
    end

    assign level            = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_held        = long_q;
    assign press_count      = count_q;
    assign evt.evt_valid    = valid_q;
    assign evt.evt_code     = code_q;
    assign evt.evt_overflow = ovf_q;

endmodule
